// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: issues data-memory requests, aligns load data,
// builds store strobes, stalls while memory is busy and owns the MEM/WB register.
module mem_stage #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] write_data_mem,
    input  logic [31:0] pc_plus4_mem,
    input  logic [4:0]  rd_mem,
    input  logic [2:0]  funct3_mem,
    input  logic        Mem_read_mem,
    input  logic        Mem_write_mem,
    input  logic        Reg_write_mem,
    input  logic [1:0]  Result_src_mem,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_read_data_wb,
    output logic [31:0] alu_result_wb,
    output logic [31:0] pc_plus4_wb,
    output logic [4:0]  rd_wb,
    output logic        Reg_write_wb,
    output logic [1:0]  Result_src_wb,
    output logic        misalign_err_wb,
    output logic        bus_err_wb
);
    localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam bit          WD_EN = (WAIT_LIMIT != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_access, misaligned, mis_drop, issue;
    logic        req_valid_c, stall_c, load_done_c, abandon_c;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c, load_data_c;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign is_access = valid_mem & (Mem_read_mem | Mem_write_mem);
    assign mis_drop  = is_access & misaligned;
    assign issue     = is_access & ~misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (funct3_mem[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_mem[0];
            default: misaligned = |alu_result_mem[1:0];
        endcase
    end

    // Request/stall control; the response is only looked at while waiting.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_valid_c = 1'b0;
        stall_c     = 1'b0;
        load_done_c = 1'b0;
        abandon_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (issue) begin
                    req_valid_c = 1'b1;
                    if (!dmem_req_ready) begin
                        stall_c = 1'b1;
                    end else if (Mem_read_mem) begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rsp_valid) begin
                    load_done_c = 1'b1;
                    state_d     = S_IDLE;
                end else if (WD_EN && cnt_q == CNT_W'(WAIT_LIMIT)) begin
                    abandon_c = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!rst_n) begin
            req_valid_c = 1'b0;
            stall_c     = 1'b0;
        end
    end

    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = write_data_mem;
        case (funct3_mem[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << alu_result_mem[1:0];
                wdata_c = {4{write_data_mem[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << {alu_result_mem[1], 1'b0};
                wdata_c = {2{write_data_mem[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_byte = dmem_rdata[7:0];
        case (alu_result_mem[1:0])
            2'b00: lane_byte = dmem_rdata[7:0];
            2'b01: lane_byte = dmem_rdata[15:8];
            2'b10: lane_byte = dmem_rdata[23:16];
            2'b11: lane_byte = dmem_rdata[31:24];
            default: ;
        endcase
        lane_half = alu_result_mem[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_mem)
            3'b000:  load_data_c = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data_c = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data_c = {24'b0, lane_byte};
            3'b101:  load_data_c = {16'b0, lane_half};
            default: load_data_c = dmem_rdata;
        endcase
    end

    assign dmem_req_valid = req_valid_c;
    assign mem_stall      = stall_c;
    assign dmem_we        = Mem_write_mem & ~Mem_read_mem;
    assign dmem_addr      = {alu_result_mem[31:2], 2'b00};
    assign dmem_wdata     = wdata_c;
    assign dmem_wstrb     = dmem_we ? wstrb_c : 4'b0000;

    // FSM state plus MEM/WB register; a stall or empty slot becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            mem_read_data_wb <= '0;
            alu_result_wb    <= '0;
            pc_plus4_wb      <= '0;
            rd_wb            <= '0;
            Reg_write_wb     <= 1'b0;
            Result_src_wb    <= '0;
            misalign_err_wb  <= 1'b0;
            bus_err_wb       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_c || !valid_mem) begin
                mem_read_data_wb <= '0;
                alu_result_wb    <= '0;
                pc_plus4_wb      <= '0;
                rd_wb            <= '0;
                Reg_write_wb     <= 1'b0;
                Result_src_wb    <= '0;
                misalign_err_wb  <= 1'b0;
                bus_err_wb       <= 1'b0;
            end else begin
                mem_read_data_wb <= load_done_c ? load_data_c : 32'h0;
                alu_result_wb    <= alu_result_mem;
                pc_plus4_wb      <= pc_plus4_mem;
                rd_wb            <= rd_mem;
                Reg_write_wb     <= Reg_write_mem & ~mis_drop & ~abandon_c;
                Result_src_wb    <= Result_src_mem;
                misalign_err_wb  <= mis_drop;
                bus_err_wb       <= abandon_c;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model predicts stall length, requests and MEM/WB
// contents per instruction; a negedge process compares every cycle.
module tb_mem_stage;
    localparam int unsigned WL    = 4;
    localparam int          NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_mem;
    logic [31:0] alu_result_mem, write_data_mem, pc_plus4_mem;
    logic [4:0]  rd_mem;
    logic [2:0]  funct3_mem;
    logic        Mem_read_mem, Mem_write_mem, Reg_write_mem;
    logic [1:0]  Result_src_mem;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] mem_read_data_wb, alu_result_wb, pc_plus4_wb;
    logic [4:0]  rd_wb;
    logic        Reg_write_wb;
    logic [1:0]  Result_src_wb;
    logic        misalign_err_wb, bus_err_wb;

    mem_stage #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .valid_mem(valid_mem),
        .alu_result_mem(alu_result_mem), .write_data_mem(write_data_mem),
        .pc_plus4_mem(pc_plus4_mem), .rd_mem(rd_mem), .funct3_mem(funct3_mem),
        .Mem_read_mem(Mem_read_mem), .Mem_write_mem(Mem_write_mem),
        .Reg_write_mem(Reg_write_mem), .Result_src_mem(Result_src_mem),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_read_data_wb(mem_read_data_wb),
        .alu_result_wb(alu_result_wb), .pc_plus4_wb(pc_plus4_wb), .rd_wb(rd_wb),
        .Reg_write_wb(Reg_write_wb), .Result_src_wb(Result_src_wb),
        .misalign_err_wb(misalign_err_wb), .bus_err_wb(bus_err_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rd_en, wr_en, reg_write;
        logic [31:0] alu, wdata, pc4;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  rsrc;
    } instr_t;

    typedef struct {
        logic [31:0] alu, pc4, data;
        logic [4:0]  rd;
        logic        reg_write;
        logic [1:0]  rsrc;
        logic        mis, bus, data_chk;
    } wb_t;

    int   n_checks = 0;
    int   n_err    = 0;
    logic exp_on   = 1'b0;
    logic exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    wb_t  exp_wb, pending, zero_wb;
    int   stall_seen, req_seen;
    logic [3:0]  last_wstrb;
    logic [31:0] last_wdata, last_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Load value from the byte/half selected by the address, extended by funct3.
    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] w);
        int unsigned lane = addr % 4;
        logic [31:0] v = w >> (8 * lane);
        case (f3)
            3'd0, 3'd4: begin
                v = v % 256;
                if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = v % 65536;
                if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] strb_model(input logic [2:0] f3, input logic [31:0] addr);
        int sz = size_of(f3);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] w);
        int sz = size_of(f3);
        if (sz == 1) return 32'(w[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(w[15:0]) * 32'h0001_0001;
        return w;
    endfunction

    function automatic instr_t mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                  input logic [31:0] alu, input logic [31:0] wd,
                                  input logic [31:0] pc4, input logic [1:0] rsrc,
                                  input logic rw, input logic [4:0] rd);
        instr_t i;
        i.valid = 1'b1; i.rd_en = rd_en; i.wr_en = wr_en; i.f3 = f3; i.alu = alu;
        i.wdata = wd; i.pc4 = pc4; i.rsrc = rsrc; i.reg_write = rw; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind = $urandom_range(0, 9);
        i.valid = (kind != 0);
        i.rd_en = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind >= 1 && kind <= 4);
        i.wr_en = (kind == 0) ? ~i.rd_en : (kind >= 5 && kind <= 7);
        i.alu   = $urandom();
        if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
        i.f3    = i.wr_en ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        i.wdata = $urandom();
        i.pc4   = $urandom();
        i.rd    = 5'($urandom_range(0, 31));
        i.rsrc  = i.rd_en ? 2'b01 : 2'($urandom_range(0, 2));
        i.reg_write = i.rd_en ? 1'b1 : (i.wr_en ? 1'b0 : 1'($urandom_range(0, 1)));
        return i;
    endfunction

    // Drive one instruction for as many cycles as the model says it occupies the MEM slot.
    task automatic run_instr(input instr_t in, input int r_dly, input int d_dly,
                             input logic [31:0] rsp_word);
        int   sz    = size_of(in.f3);
        logic acc   = in.valid && (in.rd_en || in.wr_en);
        logic mis   = acc && ((in.alu % sz) != 0);
        logic go    = acc && !mis;
        logic is_ld = go && in.rd_en;
        logic done  = is_ld && (d_dly < int'(WL));
        logic abandon = is_ld && !done;
        int   n     = !go ? 1 : (!in.rd_en ? r_dly + 1 : r_dly + 2 + (done ? d_dly : int'(WL)));
        stall_seen = 0;
        req_seen   = 0;
        for (int k = 0; k < n; k++) begin
            int j = k - r_dly - 1;
            valid_mem = in.valid; alu_result_mem = in.alu; write_data_mem = in.wdata;
            pc_plus4_mem = in.pc4; rd_mem = in.rd; funct3_mem = in.f3;
            Mem_read_mem = in.rd_en; Mem_write_mem = in.wr_en;
            Reg_write_mem = in.reg_write; Result_src_mem = in.rsrc;
            dmem_req_ready = (go && k <= r_dly) ? (k == r_dly) : 1'($urandom_range(0, 1));
            if (is_ld && j >= 0) dmem_rsp_valid = done && (j == d_dly);
            else                 dmem_rsp_valid = ($urandom_range(0, 3) == 0);
            dmem_rdata = (is_ld && j >= 0 && dmem_rsp_valid) ? rsp_word : $urandom();
            exp_stall = (k < n - 1);
            exp_req   = go && (k <= r_dly);
            exp_we    = in.wr_en && !in.rd_en;
            exp_addr  = {in.alu[31:2], 2'b00};
            exp_wstrb = exp_we ? strb_model(in.f3, in.alu) : 4'b0000;
            exp_wdata = wdata_model(in.f3, in.wdata);
            exp_wb    = pending;
            if (exp_stall || !in.valid) begin
                pending = zero_wb;
            end else begin
                pending.alu = in.alu; pending.pc4 = in.pc4; pending.rd = in.rd;
                pending.rsrc = in.rsrc;
                pending.reg_write = in.reg_write && !mis && !abandon;
                pending.mis = mis; pending.bus = abandon;
                pending.data = done ? ext_model(in.f3, in.alu, rsp_word) : 32'h0;
                pending.data_chk = done;
            end
            exp_on = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            check("mem_stall", 32'(mem_stall), 32'(exp_stall));
            check("req_valid", 32'(dmem_req_valid), 32'(exp_req));
            if (mem_stall) stall_seen++;
            if (dmem_req_valid) begin
                req_seen++;
                last_wstrb = dmem_wstrb; last_wdata = dmem_wdata; last_addr = dmem_addr;
            end
            if (exp_req) begin
                check("dmem_we", 32'(dmem_we), 32'(exp_we));
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb));
                if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
            end
            check("alu_result_wb", alu_result_wb, exp_wb.alu);
            check("pc_plus4_wb", pc_plus4_wb, exp_wb.pc4);
            check("rd_wb", 32'(rd_wb), 32'(exp_wb.rd));
            check("Reg_write_wb", 32'(Reg_write_wb), 32'(exp_wb.reg_write));
            check("Result_src_wb", 32'(Result_src_wb), 32'(exp_wb.rsrc));
            check("misalign_err_wb", 32'(misalign_err_wb), 32'(exp_wb.mis));
            check("bus_err_wb", 32'(bus_err_wb), 32'(exp_wb.bus));
            if (exp_wb.data_chk) check("mem_read_data_wb", mem_read_data_wb, exp_wb.data);
        end
    end

    function automatic logic [31:0] wb_or();
        return alu_result_wb | pc_plus4_wb | mem_read_data_wb | 32'(rd_wb) |
               32'(Reg_write_wb) | 32'(Result_src_wb) | 32'(misalign_err_wb) | 32'(bus_err_wb);
    endfunction

    initial begin
        instr_t ld;
        zero_wb = '{default: '0};
        pending = zero_wb;
        exp_wb  = zero_wb;
        rst_n = 1'b0;
        ld = mk(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h4, 2'b01, 1'b1, 5'd1);
        valid_mem = ld.valid; alu_result_mem = ld.alu; write_data_mem = ld.wdata;
        pc_plus4_mem = ld.pc4; rd_mem = ld.rd; funct3_mem = ld.f3; Mem_read_mem = 1'b1;
        Mem_write_mem = 1'b0; Reg_write_mem = 1'b1; Result_src_mem = 2'b01;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) begin @(posedge clk); #1; end
        check("reset_req_valid", 32'(dmem_req_valid), 32'h0);
        check("reset_wb_zero", wb_or(), 32'h0);
        rst_n = 1'b1;

        run_instr(mk(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h8, 2'b01, 1'b1, 5'd3), 0, 1, 32'h80AB_CD12);
        check("lb_stall_cycles", 32'(stall_seen), 32'd2);
        check("lb_data", mem_read_data_wb, 32'hFFFF_FF80);
        check("lb_reg_write", 32'(Reg_write_wb), 32'h1);
        check("lb_result_src", 32'(Result_src_wb), 32'h1);

        run_instr(mk(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'hC, 2'b01, 1'b1, 5'd4), 0, 0, 32'h8001_7F00);
        check("lhu_data", mem_read_data_wb, 32'h0000_8001);
        run_instr(mk(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h10, 2'b01, 1'b1, 5'd5), 1, 0, 32'h8001_7F00);
        check("lh_data", mem_read_data_wb, 32'hFFFF_8001);

        run_instr(mk(1'b0, 1'b1, 3'd0, 32'h201, 32'h1234_56A5, 32'h14, 2'b00, 1'b0, 5'd0), 3, 0, 32'h0);
        check("sb_req_cycles", 32'(req_seen), 32'd4);
        check("sb_stall_cycles", 32'(stall_seen), 32'd3);
        check("sb_wstrb", 32'(last_wstrb), 32'h2);
        check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        check("sb_addr", last_addr, 32'h200);

        run_instr(mk(1'b0, 1'b1, 3'd2, 32'h302, 32'hDEAD_BEEF, 32'h18, 2'b00, 1'b1, 5'd6), 0, 0, 32'h0);
        check("sw_mis_req", 32'(req_seen), 32'd0);
        check("sw_mis_stall", 32'(stall_seen), 32'd0);
        check("sw_mis_flag", 32'(misalign_err_wb), 32'h1);
        check("sw_mis_reg_write", 32'(Reg_write_wb), 32'h0);

        run_instr(mk(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h1C, 2'b01, 1'b1, 5'd7), 0, NEVER, 32'h0);
        check("wd_stall_cycles", 32'(stall_seen), 32'd5);
        check("wd_bus_err", 32'(bus_err_wb), 32'h1);
        check("wd_reg_write", 32'(Reg_write_wb), 32'h0);

        for (int t = 0; t < 400; t++) begin
            int r = $urandom_range(0, 2);
            int d = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(0, WL - 1);
            run_instr(rand_instr(), r, d, $urandom());
        end

        // Reset during a pending load, then a stray response while idle.
        run_instr(mk(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0), 0, 0, 32'h0);
        exp_on = 1'b0;
        Mem_read_mem = 1'b1; Mem_write_mem = 1'b0; funct3_mem = 3'd2; valid_mem = 1'b1;
        alu_result_mem = 32'h500; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("midload_reset_wb_zero", wb_or(), 32'h0);
        rst_n = 1'b1; valid_mem = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check("stray_rsp_stall", 32'(mem_stall), 32'h0);
        @(posedge clk); #1;
        check("stray_rsp_wb_zero", wb_or(), 32'h0);
        pending = zero_wb;

        run_instr(mk(1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 32'h1000, 2'b00, 1'b1, 5'd8), 0, 0, 32'h0);
        check("add_alu_wb", alu_result_wb, 32'h55);
        check("add_stall", 32'(stall_seen), 32'd0);
        run_instr(mk(1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 32'h1004, 2'b10, 1'b1, 5'd1), 0, 0, 32'h0);
        check("jal_pc4_wb", pc_plus4_wb, 32'h1004);
        check("jal_result_src", 32'(Result_src_wb), 32'h2);
        run_instr(mk(1'b1, 1'b0, 3'd4, 32'h601, 32'h0, 32'h20, 2'b01, 1'b1, 5'd9), 0, 0, 32'h0000_9C00);
        check("post_reset_lbu", mem_read_data_wb, 32'h0000_009C);
        run_instr(mk(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0), 0, 0, 32'h0);
        exp_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
